// File: rtl/logic_unit_pkg.sv
// Shared op and occupancy encodings for the pipelined logic unit.
package logic_unit_pkg;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_NOTA  = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_XOR   = 3'd5;
   localparam logic [2:0] OP_XNOR  = 3'd6;
   localparam logic [2:0] OP_PASSB = 3'd7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational per-lane gate function with zero/all-ones flags.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NOTA:  y = ~a;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_PASSB: y = b;
         default:  y = '0;
      endcase
   end

   assign zero = ~|y;
   assign ones = &y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, 2-entry output
// buffer (main + skid) and a running accepted-transaction count.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [2:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_y,
   output logic [2:0]         out_op,
   output logic               out_zero,
   output logic               out_ones,
   output logic [COUNT_W-1:0] txn_count
);

   logic [WIDTH-1:0] new_y;
   logic             new_zero;
   logic             new_ones;

   logic_unit_core #(.WIDTH(WIDTH)) u_core (
      .a    (in_a),
      .b    (in_b),
      .op   (in_op),
      .y    (new_y),
      .zero (new_zero),
      .ones (new_ones)
   );

   state_e state_q, state_d;
   logic   in_ready_q, in_ready_d;

   logic [WIDTH-1:0] main_y_q, main_y_d;
   logic [2:0]       main_op_q, main_op_d;
   logic             main_zero_q, main_zero_d;
   logic             main_ones_q, main_ones_d;

   logic [WIDTH-1:0] skid_y_q, skid_y_d;
   logic [2:0]       skid_op_q, skid_op_d;
   logic             skid_zero_q, skid_zero_d;
   logic             skid_ones_q, skid_ones_d;

   logic [COUNT_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic pop;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_y_d    = main_y_q;
      main_op_d   = main_op_q;
      main_zero_d = main_zero_q;
      main_ones_d = main_ones_q;
      skid_y_d    = skid_y_q;
      skid_op_d   = skid_op_q;
      skid_zero_d = skid_zero_q;
      skid_ones_d = skid_ones_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d     = ST_ONE;
               main_y_d    = new_y;
               main_op_d   = in_op;
               main_zero_d = new_zero;
               main_ones_d = new_ones;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               main_y_d    = new_y;
               main_op_d   = in_op;
               main_zero_d = new_zero;
               main_ones_d = new_ones;
            end else if (accept) begin
               state_d     = ST_TWO;
               skid_y_d    = new_y;
               skid_op_d   = in_op;
               skid_zero_d = new_zero;
               skid_ones_d = new_ones;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               state_d     = ST_ONE;
               main_y_d    = skid_y_q;
               main_op_d   = skid_op_q;
               main_zero_d = skid_zero_q;
               main_ones_d = skid_ones_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Ready is registered from the next state so out_ready never
      // reaches in_ready combinationally.
      in_ready_d = (state_d != ST_TWO);
      cnt_d      = cnt_q + COUNT_W'(accept);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         main_y_q    <= '0;
         main_op_q   <= '0;
         main_zero_q <= 1'b1;
         main_ones_q <= 1'b0;
         skid_y_q    <= '0;
         skid_op_q   <= '0;
         skid_zero_q <= 1'b1;
         skid_ones_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_y_q    <= main_y_d;
         main_op_q   <= main_op_d;
         main_zero_q <= main_zero_d;
         main_ones_q <= main_ones_d;
         skid_y_q    <= skid_y_d;
         skid_op_q   <= skid_op_d;
         skid_zero_q <= skid_zero_d;
         skid_ones_q <= skid_ones_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_y     = main_y_q;
   assign out_op    = main_op_q;
   assign out_zero  = main_zero_q;
   assign out_ones  = main_ones_q;
   assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe; a COUNT_W=4 twin checks counter wrap.
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [2:0]  in_op;
   logic        out_ready;

   logic        in_ready, out_valid, out_zero, out_ones;
   logic [7:0]  out_y;
   logic [2:0]  out_op;
   logic [15:0] txn_count;

   logic        in_ready4, out_valid4, out_zero4, out_ones4;
   logic [7:0]  out_y4;
   logic [2:0]  out_op4;
   logic [3:0]  txn_count4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_op(out_op),
      .out_zero(out_zero), .out_ones(out_ones),
      .txn_count(txn_count)
   );

   logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_y(out_y4), .out_op(out_op4),
      .out_zero(out_zero4), .out_ones(out_ones4),
      .txn_count(txn_count4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op);
      @(negedge clk);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      out_ready = 1'b0;
      #12;
      total++;
      if ({out_valid, in_ready, out_y, out_op, out_zero, out_ones} !==
          {1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0} || txn_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_vals: got v=%b r=%b y=%h op=%0d z=%b o=%b c=%0d",
                  out_valid, in_ready, out_y, out_op, out_zero, out_ones,
                  txn_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_truth();
      logic [7:0] exp [8];
      exp = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hCC};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'hF0, 8'hCC, 3'(i));
         step();
         total++;
         if (out_valid !== 1'b1 || out_y !== exp[i] || out_op !== 3'(i)) begin
            bad++;
            $display("FAIL truth_op%0d: got v=%b y=%h op=%0d want y=%h",
                     i, out_valid, out_y, out_op, exp[i]);
         end
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL truth_drain: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_flags();
      out_ready = 1'b1;
      drive(1'b1, 8'h0F, 8'hF0, 3'd0);
      step();
      total++;
      if (out_y !== 8'h00 || out_zero !== 1'b1 || out_ones !== 1'b0) begin
         bad++;
         $display("FAIL flags_and: got y=%h z=%b o=%b want 00 1 0",
                  out_y, out_zero, out_ones);
      end
      drive(1'b1, 8'h0F, 8'hF0, 3'd1);
      step();
      total++;
      if (out_y !== 8'hFF || out_zero !== 1'b0 || out_ones !== 1'b1) begin
         bad++;
         $display("FAIL flags_or: got y=%h z=%b o=%b want FF 0 1",
                  out_y, out_zero, out_ones);
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
   endtask

   task automatic test_back_pressure();
      do_reset();
      drive(1'b1, 8'hF0, 8'hCC, 3'd5);
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_y !== 8'h3C) begin
         bad++;
         $display("FAIL bp_first: got v=%b r=%b y=%h want 1 1 3c",
                  out_valid, in_ready, out_y);
      end
      drive(1'b1, 8'hF0, 8'hCC, 3'd6);
      step();
      total++;
      if (in_ready !== 1'b0 || out_y !== 8'h3C || txn_count !== 16'd2) begin
         bad++;
         $display("FAIL bp_full: got r=%b y=%h c=%0d want 0 3c 2",
                  in_ready, out_y, txn_count);
      end
      drive(1'b1, 8'hF0, 8'hCC, 3'd7);
      step();
      total++;
      if (in_ready !== 1'b0 || out_y !== 8'h3C || out_op !== 3'd5 ||
          out_valid !== 1'b1 || txn_count !== 16'd2) begin
         bad++;
         $display("FAIL bp_hold: got r=%b y=%h op=%0d v=%b c=%0d",
                  in_ready, out_y, out_op, out_valid, txn_count);
      end
      @(negedge clk);
      out_ready = 1'b1;
      step();
      total++;
      if (out_y !== 8'hC3 || out_op !== 3'd6 || in_ready !== 1'b1 ||
          txn_count !== 16'd2) begin
         bad++;
         $display("FAIL bp_pop1: got y=%h op=%0d r=%b c=%0d want c3 6 1 2",
                  out_y, out_op, in_ready, txn_count);
      end
      step();
      total++;
      if (out_y !== 8'hCC || out_op !== 3'd7 || txn_count !== 16'd3) begin
         bad++;
         $display("FAIL bp_pop2: got y=%h op=%0d c=%0d want cc 7 3",
                  out_y, out_op, txn_count);
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
      total++;
      if (out_valid !== 1'b0 || txn_count !== 16'd3) begin
         bad++;
         $display("FAIL bp_drain: got v=%b c=%0d want 0 3",
                  out_valid, txn_count);
      end
   endtask

   task automatic test_streaming();
      int errs;
      errs = 0;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(i), 8'hA5, 3'd5);
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
             out_y !== (8'(i) ^ 8'hA5))
            errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL stream_items: got %0d bad cycles want 0", errs);
      end
      total++;
      if (txn_count !== 16'd20) begin
         bad++;
         $display("FAIL stream_count: got %0d want 20", txn_count);
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
   endtask

   task automatic test_counter_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         drive(1'b1, 8'h00, 8'h00, 3'd0);
         step();
         if (i == 15) begin
            total++;
            if (txn_count4 !== 4'd15) begin
               bad++;
               $display("FAIL wrap_15: got %0d want 15", txn_count4);
            end
         end else if (i == 16) begin
            total++;
            if (txn_count4 !== 4'd0) begin
               bad++;
               $display("FAIL wrap_16: got %0d want 0", txn_count4);
            end
         end else if (i == 17) begin
            total++;
            if (txn_count4 !== 4'd1 || txn_count !== 16'd17) begin
               bad++;
               $display("FAIL wrap_17: got %0d/%0d want 1/17",
                        txn_count4, txn_count);
            end
         end
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 8'hF0, 8'hCC, 3'd1);
      step();
      drive(1'b1, 8'hF0, 8'hCC, 3'd2);
      step();
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_fill: got r=%b want 0", in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_y, out_op, out_zero, out_ones} !==
          {1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0} || txn_count !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset: got v=%b r=%b y=%h op=%0d z=%b o=%b c=%0d",
                  out_valid, in_ready, out_y, out_op, out_zero, out_ones,
                  txn_count);
      end
      step();
      total++;
      if (out_valid !== 1'b0 || txn_count !== 16'd0) begin
         bad++;
         $display("FAIL mid_ignore: got v=%b c=%0d want 0 0",
                  out_valid, txn_count);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_release: got r=%b v=%b want 1 0",
                  in_ready, out_valid);
      end
      out_ready = 1'b1;
      drive(1'b1, 8'hF0, 8'hCC, 3'd3);
      step();
      total++;
      if (out_y !== 8'h3F || out_valid !== 1'b1 || txn_count !== 16'd1) begin
         bad++;
         $display("FAIL mid_resume: got y=%h v=%b c=%0d want 3f 1 1",
                  out_y, out_valid, txn_count);
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      step();
   endtask

   initial begin
      test_reset();
      test_truth();
      test_flags();
      test_back_pressure();
      test_streaming();
      test_counter_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit: the sequential successor to the team's combinational two-input gate set.
- Accepts WIDTH-bit operand pairs plus an op select over a valid/ready handshake.
- Computes one of eight gate functions per lane and returns the result through a 2-entry output buffer (main register plus skid register).
- Used wherever gate results must be pipelined and back-pressured; also keeps a running transaction count for bring-up.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- COUNT_W, 16, width of accepted-transaction counter (>=1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair and op are presented
- in_ready  output  1  block can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  function select (encoding below)
- out_valid  output  1  result presented
- out_ready  input  1  downstream accepts result this cycle
- out_y  output  WIDTH  result
- out_op  output  3  op that produced out_y
- out_zero  output  1  out_y == 0
- out_ones  output  1  out_y == all ones
- txn_count  output  COUNT_W  number of accepted inputs, modulo 2^COUNT_W

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n; all flops clear immediately on rst_n low.
- Reset values:
  - out_valid=0, in_ready=1, out_y=0, out_op=0, out_zero=1, out_ones=0, txn_count=0.
  - Skid register contents = 0 and invalid.
- Op encoding, bitwise per lane:
  - 0 AND, 1 OR, 2 NOT A (in_b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS B.
- Handshake events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Inputs are sampled only on accept. in_a/in_b/in_op are don't-care otherwise.
- Latency: a result appears on out_y with out_valid=1 the cycle after accept, provided the buffer is not holding older data.
- Flags: out_zero/out_ones are computed with the result and registered alongside it (never combinational from out_y); they always match out_y.
- Occupancy FSM, states EMPTY / ONE / TWO:
  - EMPTY: accept -> ONE, main <= f(new).
  - ONE, accept & pop -> ONE, main <= f(new).
  - ONE, accept & !pop -> TWO, skid <= f(new).
  - ONE, !accept & pop -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: pop -> ONE, main <= skid. Otherwise hold. No accept is possible in TWO.
- Output mapping:
  - in_ready = (state != TWO), registered, no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - out_y/out_op/flags are driven from main.
- Ordering: results leave strictly in acceptance order. No drop, no duplicate.
- Output stability: while out_valid=1 & out_ready=0, out_y/out_op/flags hold stable.
- txn_count: +1 on every accept; wraps from 2^COUNT_W-1 to 0; unaffected by pop.
- WIDTH=1: out_zero = ~out_y, out_ones = out_y.
- Reset mid-operation: buffered results are discarded, the FSM returns to EMPTY, and txn_count clears.
- in_valid is ignored while rst_n is low.

Decomposition:
- Package logic_unit_pkg holds:
  - op localparams OP_AND..OP_PASSB (3-bit);
  - state encoding ST_EMPTY/ST_ONE/ST_TWO (2-bit).
- Sub-module logic_unit_core: purely combinational; takes a, b, op; produces y, zero, ones.
- logic_unit_pipe instantiates one logic_unit_core on the input side, so main and skid both store computed results.

Test Plan:
- Reset values: assert rst_n=0 mid-stream with the buffer in TWO -> all outputs at reset values within the same cycle, txn_count=0, in_ready=1 after release.
- Truth sweep: WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, ops 0..7 -> y = C0, FC, 0F, 3F, 03, 3C, C3, CC, one cycle after each accept; out_op echoes 0..7.
- Flags: op 0 with a=8'h0F, b=8'hF0 -> y=00, out_zero=1, out_ones=0. Op 1 with a=8'h0F, b=8'hF0 -> y=FF, out_zero=0, out_ones=1.
- Back-pressure: out_ready=0, three back-to-back in_valid with ops 5, 6, 7 -> first two accepted, in_ready=0 after the second, third held. Raise out_ready -> outputs in order 3C, C3, then CC. No loss.
- Simultaneous accept and pop in ONE, continuous streaming of 20 items -> in_ready stays 1, one result per cycle, txn_count=20.
- Counter wrap: COUNT_W=4, 17 accepts -> txn_count reads 15 after the 15th accept, 0 after the 16th, 1 after the 17th.
